// File: rtl/reset_ctrl.sv
`timescale 1ns/1ps
// Reset controller: async assert, synchronous release after a hold, software reset and reset cause.
// Optional watchdog compiled in when RESET_CTRL_WDT_EN is defined.
module reset_ctrl #(
   parameter int SyncStages = 2,
   parameter int HoldCycles = 16,
   parameter int WdtCycles  = 16384
) (
   input  logic       clk_i,
   input  logic       rst_n_i,
   input  logic       sw_rst_req_i,
   output logic       sw_rst_ack_o,
   input  logic       kick_i,
   output logic       rst_n_o,
   output logic       ready_o,
   output logic       wdt_expired_o,
   output logic [1:0] reset_cause_o
);

   typedef enum logic [1:0] {
      ST_SYNC  = 2'd0,
      ST_HOLD  = 2'd1,
      ST_RUN   = 2'd2,
      ST_SWRST = 2'd3
   } state_t;

   localparam int              HW        = $clog2(HoldCycles + 1);
   localparam logic [HW-1:0]   HOLD_LAST = HW'(HoldCycles - 1);
   localparam logic [1:0]      CAUSE_EXT = 2'd0;
   localparam logic [1:0]      CAUSE_SW  = 2'd1;
   localparam logic [1:0]      CAUSE_WDT = 2'd2;

   state_t                r_state;
   state_t                w_state_nxt;
   logic [SyncStages-1:0] r_sync;
   logic [HW-1:0]         r_hold_cnt;
   logic [HW-1:0]         w_hold_nxt;
   logic                  r_rst_n;
   logic                  r_ready;
   logic                  r_ack;
   logic                  w_ack_nxt;
   logic                  r_wdt;
   logic                  w_wdt_nxt;
   logic [1:0]            r_cause;
   logic [1:0]            w_cause_nxt;
   logic                  w_run_nxt;
   logic                  w_expire;

   // Release synchronizer: shifts in ones once the raw reset is released
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_sync <= '0;
      end else begin
         r_sync <= {r_sync[SyncStages-2:0], 1'b1};
      end
   end

`ifdef RESET_CTRL_WDT_EN
   localparam int            WW       = $clog2(WdtCycles);
   localparam logic [WW-1:0] WDT_LAST = WW'(WdtCycles - 1);

   logic [WW-1:0] r_wdt_cnt;

   assign w_expire = (r_state == ST_RUN) && !kick_i && (r_wdt_cnt == WDT_LAST);

   // Watchdog counter: held at zero outside RUN so it starts clean on RUN entry
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_wdt_cnt <= '0;
      end else if ((r_state != ST_RUN) || kick_i || w_expire) begin
         r_wdt_cnt <= '0;
      end else begin
         r_wdt_cnt <= r_wdt_cnt + WW'(1);
      end
   end
`else
   logic w_unused_kick;

   assign w_unused_kick = kick_i;
   assign w_expire      = 1'b0;
`endif

   // Next-state and next-output logic
   always_comb begin
      w_state_nxt = r_state;
      w_hold_nxt  = r_hold_cnt;
      w_cause_nxt = r_cause;
      w_ack_nxt   = 1'b0;
      w_wdt_nxt   = 1'b0;
      case (r_state)
         ST_SYNC: begin
            // The sync stage consumes one hold cycle, so the counter is preloaded to 1
            if (r_sync[SyncStages-1]) begin
               if (HoldCycles == 1) begin
                  w_state_nxt = ST_RUN;
               end else begin
                  w_state_nxt = ST_HOLD;
                  w_hold_nxt  = HW'(1);
               end
            end else begin
               w_state_nxt = ST_SYNC;
            end
         end
         ST_HOLD: begin
            if (r_hold_cnt == HOLD_LAST) begin
               w_state_nxt = ST_RUN;
               w_hold_nxt  = '0;
            end else begin
               w_hold_nxt  = r_hold_cnt + HW'(1);
            end
         end
         ST_RUN: begin
            if (sw_rst_req_i) begin
               w_state_nxt = ST_SWRST;
               w_ack_nxt   = 1'b1;
               w_cause_nxt = CAUSE_SW;
            end else if (w_expire) begin
               w_state_nxt = ST_HOLD;
               w_hold_nxt  = '0;
               w_wdt_nxt   = 1'b1;
               w_cause_nxt = CAUSE_WDT;
            end else begin
               w_state_nxt = ST_RUN;
            end
         end
         ST_SWRST: begin
            if (sw_rst_req_i) begin
               w_ack_nxt   = 1'b1;
            end else begin
               w_state_nxt = ST_HOLD;
               w_hold_nxt  = '0;
            end
         end
         default: begin
            w_state_nxt = ST_SYNC;
            w_hold_nxt  = '0;
            w_cause_nxt = CAUSE_EXT;
         end
      endcase
      w_run_nxt = (w_state_nxt == ST_RUN);
   end

   // State, hold counter and registered outputs
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_state    <= ST_SYNC;
         r_hold_cnt <= '0;
         r_rst_n    <= 1'b0;
         r_ready    <= 1'b0;
         r_ack      <= 1'b0;
         r_wdt      <= 1'b0;
         r_cause    <= CAUSE_EXT;
      end else begin
         r_state    <= w_state_nxt;
         r_hold_cnt <= w_hold_nxt;
         r_rst_n    <= w_run_nxt;
         r_ready    <= w_run_nxt;
         r_ack      <= w_ack_nxt;
         r_wdt      <= w_wdt_nxt;
         r_cause    <= w_cause_nxt;
      end
   end

   assign rst_n_o       = r_rst_n;
   assign ready_o       = r_ready;
   assign sw_rst_ack_o  = r_ack;
   assign wdt_expired_o = r_wdt;
   assign reset_cause_o = r_cause;

endmodule

// File: tb/tb_reset_ctrl.sv
`timescale 1ns/1ps
// Scoreboard bench for reset_ctrl; watchdog scenarios run when RESET_CTRL_WDT_EN is defined,
// otherwise a long unkicked RUN stretch checks that no watchdog exists.
module tb_reset_ctrl;
   localparam int SYNC = 2;
   localparam int HOLD = 16;
`ifdef RESET_CTRL_WDT_EN
   localparam int WDT  = 8;
`else
   localparam int WDT  = 16384;
`endif
   localparam int REL  = SYNC + HOLD;

   typedef struct packed {
      logic       rst_n;
      logic       ready;
      logic       ack;
      logic       wdt;
      logic [1:0] cause;
   } exp_t;

   logic       clk_i = 1'b0;
   logic       rst_n_i;
   logic       sw_rst_req_i;
   logic       sw_rst_ack_o;
   logic       kick_i;
   logic       rst_n_o;
   logic       ready_o;
   logic       wdt_expired_o;
   logic [1:0] reset_cause_o;

   exp_t       sb[$];
   int         total = 0;
   int         bad   = 0;
   logic [1:0] cause_m;

   reset_ctrl #(
      .SyncStages (SYNC),
      .HoldCycles (HOLD),
      .WdtCycles  (WDT)
   ) dut (
      .clk_i         (clk_i),
      .rst_n_i       (rst_n_i),
      .sw_rst_req_i  (sw_rst_req_i),
      .sw_rst_ack_o  (sw_rst_ack_o),
      .kick_i        (kick_i),
      .rst_n_o       (rst_n_o),
      .ready_o       (ready_o),
      .wdt_expired_o (wdt_expired_o),
      .reset_cause_o (reset_cause_o)
   );

   always #5 clk_i = ~clk_i;

   function automatic exp_t mk(input logic rn, input logic ack, input logic wdt, input logic [1:0] cause);
      exp_t e;
      e.rst_n = rn;
      e.ready = rn;
      e.ack   = ack;
      e.wdt   = wdt;
      e.cause = cause;
      return e;
   endfunction

   function automatic exp_t sample();
      exp_t o;
      o = {rst_n_o, ready_o, sw_rst_ack_o, wdt_expired_o, reset_cause_o};
      return o;
   endfunction

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic test_release(input string name);
      exp_t e, o;
      rst_n_i = 1'b1;
      for (int k = 1; k <= REL + 2; k++) begin
         sb.push_back(mk(k >= REL, 1'b0, 1'b0, cause_m));
         tick();
         e = sb.pop_front(); o = sample(); total++;
         if (o !== e) begin bad++; $display("FAIL %s edge=%0d got=%b want=%b", name, k, o, e); end
      end
   endtask

   task automatic test_reset();
      exp_t e, o;
      rst_n_i = 1'b0; sw_rst_req_i = 1'b0; kick_i = 1'b1;
      #2;
      for (int k = 0; k < 3; k++) begin
         sb.push_back(mk(1'b0, 1'b0, 1'b0, 2'd0));
         if (k > 0) tick();
         e = sb.pop_front(); o = sample(); total++;
         if (o !== e) begin bad++; $display("FAIL reset_state step=%0d got=%b want=%b", k, o, e); end
      end
      cause_m = 2'd0;
      test_release("ext_release");
   endtask

   task automatic test_sw_reset();
      exp_t e, o;
      cause_m = 2'd1;
      for (int k = 1; k <= HOLD + 8; k++) begin
         sw_rst_req_i = (k <= 5);
         sb.push_back(mk(k >= HOLD + 6, k <= 5, 1'b0, cause_m));
         tick();
         e = sb.pop_front(); o = sample(); total++;
         if (o !== e) begin bad++; $display("FAIL sw_reset edge=%0d got=%b want=%b", k, o, e); end
      end
      sw_rst_req_i = 1'b0;
   endtask

`ifdef RESET_CTRL_WDT_EN
   task automatic test_watchdog();
      exp_t e, o;
      for (int k = 1; k <= WDT + HOLD + 2; k++) begin
         kick_i = (k > WDT + HOLD);
         sb.push_back(mk((k < WDT) || (k >= WDT + HOLD), 1'b0, k == WDT, (k >= WDT) ? 2'd2 : 2'd1));
         tick();
         e = sb.pop_front(); o = sample(); total++;
         if (o !== e) begin bad++; $display("FAIL watchdog edge=%0d got=%b want=%b", k, o, e); end
      end
      cause_m = 2'd2;
   endtask

   task automatic test_kick_period();
      exp_t e, o;
      for (int k = 1; k <= 8 * 7; k++) begin
         kick_i = ((k % 7) == 0);
         sb.push_back(mk(1'b1, 1'b0, 1'b0, cause_m));
         tick();
         e = sb.pop_front(); o = sample(); total++;
         if (o !== e) begin bad++; $display("FAIL kick_period edge=%0d got=%b want=%b", k, o, e); end
      end
      kick_i = 1'b1;
   endtask

   task automatic test_conflicts();
      exp_t e, o;
      for (int k = 1; k <= 2 * WDT + HOLD + 3; k++) begin
         kick_i       = (k == WDT) || (k > 2 * WDT + 1);
         sw_rst_req_i = (k == 2 * WDT);
         sb.push_back(mk((k < 2 * WDT) || (k >= 2 * WDT + 1 + HOLD), k == 2 * WDT, 1'b0,
                         (k >= 2 * WDT) ? 2'd1 : 2'd2));
         tick();
         e = sb.pop_front(); o = sample(); total++;
         if (o !== e) begin bad++; $display("FAIL conflict edge=%0d got=%b want=%b", k, o, e); end
      end
      sw_rst_req_i = 1'b0; kick_i = 1'b1;
      cause_m = 2'd1;
   endtask
`else
   task automatic test_no_wdt();
      exp_t e, o;
      kick_i = 1'b0;
      for (int k = 1; k <= 20000; k++) begin
         sb.push_back(mk(1'b1, 1'b0, 1'b0, cause_m));
         tick();
         e = sb.pop_front(); o = sample(); total++;
         if (o !== e) begin bad++; $display("FAIL no_wdt cycle=%0d got=%b want=%b", k, o, e); end
      end
      kick_i = 1'b1;
   endtask
`endif

   // mode 0: from RUN, 1: mid-SWRST, 2: mid-HOLD after a software reset
   task automatic test_async(input int mode);
      exp_t e, o;
      int   steps;
      kick_i = 1'b1;
      steps  = (mode == 0) ? 1 : ((mode == 1) ? 2 : 4);
      for (int k = 1; k <= steps; k++) begin
         sw_rst_req_i = (mode == 1) || ((mode == 2) && (k == 1));
         if (mode == 0) sb.push_back(mk(1'b1, 1'b0, 1'b0, cause_m));
         else           sb.push_back(mk(1'b0, (mode == 1) || (k == 1), 1'b0, 2'd1));
         tick();
         e = sb.pop_front(); o = sample(); total++;
         if (o !== e) begin bad++; $display("FAIL async_pre mode=%0d step=%0d got=%b want=%b", mode, k, o, e); end
      end
      #2;
      rst_n_i = 1'b0; sw_rst_req_i = 1'b0;
      cause_m = 2'd0;
      #1;
      for (int k = 0; k < 2; k++) begin
         sb.push_back(mk(1'b0, 1'b0, 1'b0, 2'd0));
         if (k > 0) tick();
         e = sb.pop_front(); o = sample(); total++;
         if (o !== e) begin bad++; $display("FAIL async_drop mode=%0d step=%0d got=%b want=%b", mode, k, o, e); end
      end
      test_release("async_release");
   endtask

   initial begin
      test_reset();
      test_sw_reset();
`ifdef RESET_CTRL_WDT_EN
      test_watchdog();
      test_kick_period();
      test_conflicts();
`else
      test_no_wdt();
`endif
      test_async(1);
      test_async(2);
      test_async(0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/reset_ctrl.md
# reset_ctrl

Per-clock-domain reset controller between the bench/board clock-and-reset source and the core. It takes the raw asynchronous active-low reset, asserts core reset asynchronously, releases it synchronously after a configurable hold, and adds software-requested reset and an optional watchdog. It also reports the cause of the last reset.

## Interface

Parameters:
- `SyncStages`, 2: flops in the reset-release synchronizer; legal range is 2 or more.
- `HoldCycles`, 16: cycles core reset stays low after synchronized release; legal range is 1 or more.
- `WdtCycles`, 16384: watchdog timeout in RUN cycles without a kick; legal range is 2 or more.

Ports:
- `clk_i` in 1: the single clock.
- `rst_n_i` in 1: reset, asynchronous and active-low.
- `sw_rst_req_i` in 1: software reset request, level, four-phase handshake.
- `sw_rst_ack_o` out 1: software reset acknowledge.
- `kick_i` in 1: watchdog kick, one cycle or longer.
- `rst_n_o` out 1: core reset, active-low, asserted asynchronously and deasserted synchronously.
- `ready_o` out 1: high only in RUN.
- `wdt_expired_o` out 1: one-cycle pulse on watchdog timeout.
- `reset_cause_o` out 2: cause of the last reset. 0 = external, 1 = software, 2 = watchdog, 3 = reserved.

## Operation

States:
- SYNC: waiting for the synchronizer output to go high.
- HOLD: hold counter running.
- RUN: normal operation.
- SWRST: waiting for the software requester to release.

Rules:
- `rst_n_i` low forces, immediately and combinationally via the async clear:
  - state to SYNC, synchronizer to all zeros, counters to 0;
  - `rst_n_o`=0, `ready_o`=0, `sw_rst_ack_o`=0, `wdt_expired_o`=0, `reset_cause_o`=0.
- SYNC to HOLD: when the last synchronizer stage reads 1.
- HOLD: counts HoldCycles cycles, then enters RUN. On that edge `rst_n_o` and `ready_o` go to 1.
- RUN with `sw_rst_req_i`=1 sampled: next edge enters SWRST.
  - `rst_n_o`=0, `ready_o`=0, `sw_rst_ack_o`=1, `reset_cause_o`=1.
- SWRST: stays while `sw_rst_req_i`=1. On the first edge sampling it 0, `sw_rst_ack_o`=0 and the state enters HOLD.
- Watchdog expiry in RUN: next edge enters HOLD.
  - `rst_n_o`=0, `ready_o`=0, `reset_cause_o`=2.
  - `wdt_expired_o`=1 for exactly that one cycle.
- `reset_cause_o` changes only on entry to SWRST or on watchdog expiry, and holds its value otherwise.
  - External reset clears it to 0 (external).
- `sw_rst_req_i` is ignored outside RUN. A request held across HOLD is taken on the first RUN cycle.
- `kick_i` is ignored outside RUN.

## Timing

- Edge numbering: edge 1 is the first `clk_i` posedge with `rst_n_i` high.
- External release latency: `rst_n_o` rises on edge SyncStages+HoldCycles. With defaults that is edge 18.
- Software reset:
  - Request sampled high on edge N gives `rst_n_o`=0 and `sw_rst_ack_o`=1 after edge N+1.
  - Request sampled low on edge M gives `sw_rst_ack_o`=0 after edge M+1; `rst_n_o` rises on edge M+1+HoldCycles.
- Watchdog counter:
  - Width is `$clog2(WdtCycles)`.
  - Cleared on RUN entry and on any RUN cycle with `kick_i`=1.
  - Otherwise increments once per RUN cycle.
  - Expiry is the edge where the counter equals WdtCycles-1 and `kick_i`=0. That is the WdtCycles-th consecutive unkicked RUN cycle.
- Same-cycle conflicts:
  - `kick_i` plus expiry: the kick wins and there is no expiry.
  - `sw_rst_req_i` plus expiry: the software reset wins, with cause 1 and no `wdt_expired_o` pulse.
- `rst_n_i` asserted mid-HOLD, mid-SWRST or mid-RUN: all outputs return to their reset values with no clock edge needed. Release restarts the full SYNC and HOLD sequence.
- All outputs except the async reset path are registered; there are no combinational input-to-output paths.

## Configuration

- Macro: `RESET_CTRL_WDT_EN`.
- Defined: the watchdog counter, `kick_i` and the expiry path exist as described.
- Undefined:
  - no watchdog counter is synthesized;
  - `kick_i` is unused, `wdt_expired_o` is tied to 0;
  - `reset_cause_o` never takes value 2.

## Test plan

- Release `rst_n_i` with defaults: `rst_n_o` and `ready_o` are 0 through edge 17 and 1 after edge 18; `reset_cause_o`=0.
- Software reset: in RUN, raise `sw_rst_req_i` for 5 cycles then drop it.
  - `sw_rst_ack_o` and core reset assert one edge after the request and ack drops one edge after the request falls.
  - `rst_n_o` rises 16 edges later and `reset_cause_o`=1.
- Watchdog, `RESET_CTRL_WDT_EN` on, `WdtCycles`=8:
  - 8 unkicked RUN cycles give a single-cycle `wdt_expired_o` pulse, `reset_cause_o`=2, and a 16-cycle hold before RUN.
  - A kick every 7 cycles never expires.
- Conflicts: a kick and a software request each coinciding with the expiry cycle.
  - Kick: no expiry.
  - Software request: SWRST with cause 1 and no `wdt_expired_o` pulse.
- Async reset mid-HOLD and mid-SWRST: `rst_n_o`, `ready_o` and `sw_rst_ack_o` drop before the next edge and `reset_cause_o` returns to 0. After release the full 18-edge sequence repeats.
- Build with `RESET_CTRL_WDT_EN` undefined and leave `kick_i` low for 20000 cycles: `wdt_expired_o` stays 0 and the block stays in RUN.
